// File: rtl/draw_scheduler_pkg.sv
// Shared screen geometry, coordinate widths and FSM encoding for the draw scheduler.
package draw_scheduler_pkg;

    localparam int X_W  = 9;
    localparam int Y_W  = 8;
    localparam int XS_W = X_W + 1;
    localparam int YS_W = Y_W + 1;

    localparam logic [XS_W-1:0] SCREEN_W = 10'd320;
    localparam logic [YS_W-1:0] SCREEN_H = 9'd240;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Sums are one bit wider than the coordinate so off-screen pixels never alias on-screen.
    function automatic logic on_screen(input logic [XS_W-1:0] sx, input logic [YS_W-1:0] sy);
        return (sx < SCREEN_W) && (sy < SCREEN_H);
    endfunction

endpackage

// File: rtl/draw_scheduler_rect_scanner.sv
// Row-major box walker: i runs fastest across the width, j steps once per row.
module rect_scanner #(
    parameter int SIZE_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              step_i,
    input  logic [SIZE_W-1:0] w_i,
    input  logic [SIZE_W-1:0] h_i,
    output logic [SIZE_W-1:0] i_nxt_o,
    output logic [SIZE_W-1:0] j_nxt_o,
    output logic              last_o
);

    logic [SIZE_W-1:0] i_q, j_q;
    logic [SIZE_W-1:0] w_m1, h_m1;
    logic              row_end;

    assign w_m1    = w_i - SIZE_W'(1);
    assign h_m1    = h_i - SIZE_W'(1);
    assign row_end = (i_q == w_m1);
    assign last_o  = row_end && (j_q == h_m1);
    assign i_nxt_o = row_end ? '0 : i_q + SIZE_W'(1);
    assign j_nxt_o = row_end ? j_q + SIZE_W'(1) : j_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            i_q <= '0;
            j_q <= '0;
        end else if (step_i) begin
            i_q <= i_nxt_o;
            j_q <= j_nxt_o;
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Round-robin owner of the VGA plot port: latches one requester's box and scans it
// one clipped pixel per clock, then pulses that requester's done bit.
module draw_scheduler
    import draw_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SIZE_W  = 6,
    parameter int C_W     = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*X_W-1:0]    req_x,
    input  logic [NUM_REQ*Y_W-1:0]    req_y,
    input  logic [NUM_REQ*SIZE_W-1:0] req_w,
    input  logic [NUM_REQ*SIZE_W-1:0] req_h,
    input  logic [NUM_REQ*C_W-1:0]    req_colour,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic [X_W-1:0]            vga_x,
    output logic [Y_W-1:0]            vga_y,
    output logic [C_W-1:0]            vga_colour,
    output logic                      vga_plot
);

    localparam int G_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [G_W-1:0] LAST_RST = G_W'(NUM_REQ - 1);

    state_e            state_q, state_d;
    logic [G_W-1:0]    grant_q, grant_d, last_q, last_d;
    logic [G_W-1:0]    rr_pick, cand;
    logic              rr_found;

    logic [X_W-1:0]    x_q, x_d, win_x;
    logic [Y_W-1:0]    y_q, y_d, win_y;
    logic [SIZE_W-1:0] w_q, w_d, win_w;
    logic [SIZE_W-1:0] h_q, h_d, win_h;
    logic [C_W-1:0]    c_q, c_d, win_c;

    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic               plot_q, plot_d;
    logic [X_W-1:0]     vx_q, vx_d;
    logic [Y_W-1:0]     vy_q, vy_d;
    logic [C_W-1:0]     vc_q, vc_d;

    logic               sc_clear, sc_step, sc_last;
    logic [SIZE_W-1:0]  i_nxt, j_nxt;
    logic [XS_W-1:0]    sx;
    logic [YS_W-1:0]    sy;

    rect_scanner #(.SIZE_W(SIZE_W)) u_scan (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (sc_clear),
        .step_i  (sc_step),
        .w_i     (w_q),
        .h_i     (h_q),
        .i_nxt_o (i_nxt),
        .j_nxt_o (j_nxt),
        .last_o  (sc_last)
    );

    assign win_x = req_x[int'(grant_q)*X_W +: X_W];
    assign win_y = req_y[int'(grant_q)*Y_W +: Y_W];
    assign win_w = req_w[int'(grant_q)*SIZE_W +: SIZE_W];
    assign win_h = req_h[int'(grant_q)*SIZE_W +: SIZE_W];
    assign win_c = req_colour[int'(grant_q)*C_W +: C_W];

    // Search starts one past the last served requester so every waiter is reached in turn.
    always_comb begin
        rr_pick  = last_q;
        rr_found = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = G_W'((int'(last_q) + k) % NUM_REQ);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_pick  = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        x_d      = x_q;
        y_d      = y_q;
        w_d      = w_q;
        h_d      = h_q;
        c_d      = c_q;
        done_d   = '0;
        plot_d   = 1'b0;
        vx_d     = vx_q;
        vy_d     = vy_q;
        vc_d     = vc_q;
        sc_clear = 1'b0;
        sc_step  = 1'b0;
        sx       = '0;
        sy       = '0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_LATCH;
                    grant_d = rr_pick;
                end
            end
            S_LATCH: begin
                x_d      = win_x;
                y_d      = win_y;
                w_d      = win_w;
                h_d      = win_h;
                c_d      = win_c;
                sc_clear = 1'b1;
                if (win_w == '0 || win_h == '0) begin
                    state_d         = S_DONE;
                    done_d[grant_q] = 1'b1;
                end else begin
                    state_d = S_SCAN;
                    sx      = XS_W'(win_x);
                    sy      = YS_W'(win_y);
                    vx_d    = win_x;
                    vy_d    = win_y;
                    vc_d    = win_c;
                    plot_d  = on_screen(sx, sy);
                end
            end
            S_SCAN: begin
                // Outputs are registered, so each cycle loads the pixel for the next one.
                if (sc_last) begin
                    state_d         = S_DONE;
                    done_d[grant_q] = 1'b1;
                end else begin
                    sc_step = 1'b1;
                    sx      = XS_W'(x_q) + XS_W'(i_nxt);
                    sy      = YS_W'(y_q) + YS_W'(j_nxt);
                    vx_d    = sx[X_W-1:0];
                    vy_d    = sy[Y_W-1:0];
                    plot_d  = on_screen(sx, sy);
                end
            end
            S_DONE: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= LAST_RST;
            last_q  <= LAST_RST;
            done_q  <= '0;
            busy_q  <= 1'b0;
            plot_q  <= 1'b0;
            vx_q    <= '0;
            vy_q    <= '0;
            vc_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            plot_q  <= plot_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            vc_q    <= vc_d;
        end
    end

    always_ff @(posedge clock) begin
        x_q <= x_d;
        y_q <= y_d;
        w_q <= w_d;
        h_q <= h_d;
        c_q <= c_d;
    end

    assign done       = done_q;
    assign busy       = busy_q;
    assign vga_plot   = plot_q;
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = vc_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: directed boxes, randomized boxes and arbitration scenarios
// compared against a pixel-list model derived from box geometry.
module tb_draw_scheduler;

    localparam int NUM_REQ = 4;
    localparam int SIZE_W  = 6;
    localparam int C_W     = 3;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*9-1:0]      req_x;
    logic [NUM_REQ*8-1:0]      req_y;
    logic [NUM_REQ*SIZE_W-1:0] req_w;
    logic [NUM_REQ*SIZE_W-1:0] req_h;
    logic [NUM_REQ*C_W-1:0]    req_colour;
    logic [NUM_REQ-1:0]        done;
    logic                      busy;
    logic [8:0]                vga_x;
    logic [7:0]                vga_y;
    logic [C_W-1:0]            vga_colour;
    logic                      vga_plot;

    int checks = 0;
    int errors = 0;

    draw_scheduler #(.NUM_REQ(NUM_REQ), .SIZE_W(SIZE_W), .C_W(C_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .done       (done),
        .busy       (busy),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_box(input int k, input int x, input int y, input int w, input int h, input int col);
        req_x[k*9 +: 9]                = 9'(x);
        req_y[k*8 +: 8]                = 8'(y);
        req_w[k*SIZE_W +: SIZE_W]      = SIZE_W'(w);
        req_h[k*SIZE_W +: SIZE_W]      = SIZE_W'(h);
        req_colour[k*C_W +: C_W]       = C_W'(col);
    endtask

    // One lone request from idle; expected trace comes from the box geometry alone.
    task automatic run_box(input int k, input int x, input int y, input int w, input int h,
                           input int col, input string tag);
        int n_cyc, px, py;
        logic ep;
        set_box(k, x, y, w, h, col);
        req[k] = 1'b1;
        tick;
        checks++;
        if (vga_plot !== 1'b0 || busy !== 1'b1 || done !== '0)
            $display("FAIL %s latch: plot=%b busy=%b done=%b, want plot=0 busy=1 done=0",
                     tag, vga_plot, busy, done);
        n_cyc = (w == 0 || h == 0) ? 0 : w * h;
        for (int n = 0; n < n_cyc; n++) begin
            tick;
            px = x + (n % w);
            py = y + (n / w);
            ep = (px < 320) && (py < 240);
            checks++;
            if (vga_plot !== ep || done !== '0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s scan n=%0d: plot=%b done=%b busy=%b, want plot=%b done=0 busy=1",
                         tag, n, vga_plot, done, busy, ep);
            end
            if (ep) begin
                checks++;
                if (vga_x !== 9'(px) || vga_y !== 8'(py) || vga_colour !== C_W'(col)) begin
                    errors++;
                    $display("FAIL %s pixel n=%0d: (%0d,%0d) col=%0d, want (%0d,%0d) col=%0d",
                             tag, n, vga_x, vga_y, vga_colour, px, py, col);
                end
            end
            if (n == 0) set_box(k, $urandom, $urandom, $urandom, $urandom, $urandom);
        end
        tick;
        checks++;
        if (done !== NUM_REQ'(1 << k) || vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL %s done: done=%b plot=%b, want done=%b plot=0",
                     tag, done, vga_plot, NUM_REQ'(1 << k));
        end
        req[k] = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || done !== '0) begin
            errors++;
            $display("FAIL %s idle: busy=%b done=%b, want busy=0 done=0", tag, busy, done);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req   = '0;
        req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
        tick;
        tick;
        checks++;
        if (done !== '0 || busy !== 1'b0 || vga_plot !== 1'b0 ||
            vga_x !== '0 || vga_y !== '0 || vga_colour !== '0) begin
            errors++;
            $display("FAIL reset: done=%b busy=%b plot=%b x=%0d y=%0d col=%0d, want all 0",
                     done, busy, vga_plot, vga_x, vga_y, vga_colour);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        run_box(0, 10, 20, 2, 2, 3, "basic");
    endtask

    task automatic test_zero_area;
        run_box(1, 40, 40, 0, 5, 6, "zero_w");
        run_box(2, 40, 40, 7, 0, 5, "zero_h");
    endtask

    task automatic test_clip;
        run_box(3, 318, 239, 4, 2, 7, "clip");
        run_box(0, 500, 250, 3, 3, 2, "offscreen");
    endtask

    task automatic test_big;
        run_box(1, 100, 50, 63, 63, 4, "big");
    endtask

    task automatic test_random;
        for (int t = 0; t < 20; t++) begin
            run_box($urandom_range(0, NUM_REQ - 1), $urandom_range(0, 340), $urandom_range(0, 250),
                    $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 7), "random");
        end
    endtask

    task automatic test_round_robin;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int ndone = 0;
        reset = 1'b1;
        for (int k = 0; k < NUM_REQ; k++)
            set_box(k, 20 * k, 10, $urandom_range(1, 3), $urandom_range(1, 3), k + 1);
        req = '1;
        tick;
        reset = 1'b0;
        for (int cyc = 0; cyc < 400 && ndone < 5; cyc++) begin
            tick;
            if (vga_plot === 1'b1) begin
                checks++;
                if (vga_colour !== C_W'(exp_order[ndone] + 1)) begin
                    errors++;
                    $display("FAIL rr colour: col=%0d, want %0d", vga_colour, exp_order[ndone] + 1);
                end
            end
            if (done !== '0) begin
                checks++;
                if (done !== NUM_REQ'(1 << exp_order[ndone])) begin
                    errors++;
                    $display("FAIL rr grant %0d: done=%b, want %b",
                             ndone, done, NUM_REQ'(1 << exp_order[ndone]));
                end
                ndone++;
                if (ndone == 5) req = '0;
            end
        end
        checks++;
        if (ndone != 5) begin
            errors++;
            $display("FAIL rr timeout: dones=%0d, want 5", ndone);
        end
        tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid_scan;
        int seen_done = 0;
        int ndone = 0;
        set_box(3, 5, 5, 10, 10, 1);
        req[3] = 1'b1;
        for (int c = 0; c < 21; c++) tick;
        reset = 1'b1;
        req   = '0;
        tick;
        checks++;
        if (vga_plot !== 1'b0 || busy !== 1'b0 || done !== '0) begin
            errors++;
            $display("FAIL midreset: plot=%b busy=%b done=%b, want 0 0 0", vga_plot, busy, done);
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (done !== '0 || busy !== 1'b0) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL midreset quiet: active cycles=%0d, want 0", seen_done);
        end
        set_box(0, 30, 30, 2, 1, 2);
        set_box(2, 60, 60, 1, 2, 5);
        req[0] = 1'b1;
        req[2] = 1'b1;
        for (int cyc = 0; cyc < 100 && ndone < 2; cyc++) begin
            tick;
            if (done !== '0) begin
                checks++;
                if (done !== ((ndone == 0) ? 4'b0001 : 4'b0100)) begin
                    errors++;
                    $display("FAIL midreset order %0d: done=%b, want %b",
                             ndone, done, (ndone == 0) ? 4'b0001 : 4'b0100);
                end
                req = req & ~done;
                ndone++;
            end
        end
        checks++;
        if (ndone != 2) begin
            errors++;
            $display("FAIL midreset timeout: dones=%0d, want 2", ndone);
        end
        req = '0;
        tick;
        tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_area;
        test_clip;
        test_big;
        test_random;
        test_round_robin;
        test_reset_mid_scan;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
